// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer that lends one iterative shift-add multiplier to NUM_REQ requesters
// and returns each registered 2*WIDTH product to the requester that asked for it.
module mul_share_ctrl #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [2*WIDTH-1:0]       resp_product,
   output logic [ID_W-1:0]          resp_id,
   output logic                     busy,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   output logic                     mul_start,
   input  logic [2*WIDTH-1:0]       mul_product
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      CAPT = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    rr_nxt;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_found;
   logic [ID_W:0]      cand_sum;
   logic [ID_W-1:0]    cand;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;

   // Scan from the highest offset down so the candidate closest to rr_ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand_sum >= (ID_W+1)'(NUM_REQ))
            cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
         cand = cand_sum[ID_W-1:0];
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign rr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // req_ready only rises toward a requester whose req_valid is high, and resp_valid holds
   // until the owner's resp_ready is seen, so neither side ever needs to drop or repeat data.
   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready = NUM_REQ'(1) << grant_idx;
               state_nxt = LOAD;
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            if (cnt == '0)
               state_nxt = CAPT;
         end
         CAPT: state_nxt = RESP;
         RESP: begin
            resp_valid = NUM_REQ'(1) << resp_id;
            if (resp_ready[resp_id])
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         cnt          <= '0;
         op_a         <= '0;
         op_b         <= '0;
         resp_product <= '0;
         resp_id      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op_a    <= sel_a;
                  op_b    <= sel_b;
                  resp_id <= grant_idx;
                  rr_ptr  <= rr_nxt;
               end
            end
            LOAD: cnt <= CNT_W'(WIDTH - 1);
            RUN:  cnt <= cnt - 1'b1;
            // One cycle after the last iteration, so the final accumulate has settled.
            CAPT: resp_product <= mul_product;
            default: ;
         endcase
      end
   end

   assign mul_start = (state == LOAD);
   assign busy      = (state != IDLE);
   assign mul_a     = op_a;
   assign mul_b     = op_b;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: behavioural shift-add multiplier, cycle-level job model with a
// product scoreboard, directed scenarios with literal expectations, then random traffic.
module tb_mul_share_ctrl;

   localparam int W   = 32;
   localparam int N   = 2;
   localparam int LAT = W + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a = '0;
   logic [N*W-1:0]   req_b = '0;
   logic [N-1:0]     resp_valid;
   logic [N-1:0]     resp_ready = '0;
   logic [2*W-1:0]   resp_product;
   logic [0:0]       resp_id;
   logic             busy;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic             mul_start;
   logic [2*W-1:0]   mul_product;

   int               checks = 0;
   int               failures = 0;
   logic [2*W-1:0]   exp_q[$];
   int               grant_q[$];
   bit               chk_en = 1'b0;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   mul_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .ID_W(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_product (resp_product),
      .resp_id      (resp_id),
      .busy         (busy),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_start    (mul_start),
      .mul_product  (mul_product)
   );

   // Attached multiplier: start edge loads operands, then one shift-add step per edge for W edges.
   logic [2*W-1:0] m_acc = '0;
   logic [W-1:0]   m_ma = '0;
   logic [W-1:0]   m_mb = '0;
   int             m_i = W;

   always @(posedge clk) begin
      if (mul_start) begin
         m_acc <= '0;
         m_ma  <= mul_a;
         m_mb  <= mul_b;
         m_i   <= 0;
      end else if (m_i < W) begin
         if (((m_mb >> m_i) & W'(1)) != '0)
            m_acc <= m_acc + ({{W{1'b0}}, m_ma} << m_i);
         m_i <= m_i + 1;
      end
   end
   assign mul_product = m_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Job model: idle, or a job of a given age (edges since accept); response due at age LAT.
   bit             m_active = 1'b0;
   int             m_age = 0;
   int             m_id = 0;
   int             m_rr = 0;
   logic [W-1:0]   m_opa = '0;
   logic [W-1:0]   m_opb = '0;
   logic [2*W-1:0] m_prod = '0;

   always @(negedge clk) begin
      logic [N-1:0] e_ready;
      logic [N-1:0] e_rv;
      int g;
      g = -1;
      if (!m_active)
         for (int k = 0; k < N; k++)
            if (g < 0 && ((req_valid >> ((m_rr + k) % N)) & N'(1)) != '0)
               g = (m_rr + k) % N;
      e_ready = (g >= 0) ? (N'(1) << g) : '0;
      e_rv    = (m_active && m_age >= LAT) ? (N'(1) << m_id) : '0;
      if (chk_en) begin
         check("req_ready", 64'(req_ready), 64'(e_ready));
         check("resp_valid", 64'(resp_valid), 64'(e_rv));
         check("busy", 64'(busy), 64'(m_active));
         check("mul_start", 64'(mul_start), 64'(m_active && m_age == 0));
         check("mul_a", 64'(mul_a), 64'(m_opa));
         check("mul_b", 64'(mul_b), 64'(m_opb));
         check("resp_id", 64'(resp_id), 64'(m_id));
         check("resp_product", resp_product, m_prod);
         if (!rst && (req_ready & req_valid) != '0)
            grant_q.push_back(int'(req_ready[1]));
      end
      if (rst) begin
         m_active = 1'b0;
         m_age    = 0;
         m_id     = 0;
         m_rr     = 0;
         m_opa    = '0;
         m_opb    = '0;
         m_prod   = '0;
         exp_q.delete();
      end else if (!m_active) begin
         if (g >= 0) begin
            m_active = 1'b1;
            m_age    = 0;
            m_id     = g;
            m_opa    = req_a[g*W +: W];
            m_opb    = req_b[g*W +: W];
            m_rr     = (g + 1) % N;
            exp_q.push_back(64'(m_opa) * 64'(m_opb));
         end
      end else if (m_age >= LAT) begin
         if (((resp_ready >> m_id) & N'(1)) != '0) begin
            m_active = 1'b0;
            if (chk_en && exp_q.size() > 0)
               check("scoreboard_product", resp_product, exp_q.pop_front());
         end
      end else begin
         m_age++;
         if (m_age == LAT)
            m_prod = 64'(m_opa) * 64'(m_opb);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [N-1:0] also, output logic [N-1:0] gnt,
                         output logic [2*W-1:0] p, output int lat);
      int n;
      n = 0;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_valid  = also | (N'(1) << id);
      resp_ready = N'(1) << id;
      @(negedge clk);
      while (((req_ready >> id) & N'(1)) == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("accept_timeout", 64'(n), 64'(0));
      gnt = req_ready;
      tick();
      req_valid = '0;
      lat = 0;
      while (((resp_valid >> id) & N'(1)) == '0 && lat < 300) begin
         tick();
         lat++;
      end
      p = resp_product;
      tick();
      resp_ready = '0;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   logic [N-1:0]   gnt;
   logic [2*W-1:0] p;
   int             lat;
   int             n;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_resp_valid", 64'(resp_valid), 64'(0));
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_product", resp_product, 64'(0));
      tick();

      do_job(0, 32'd7, 32'd6, 2'b00, gnt, p, lat);
      check("basic_grant", 64'(gnt), 64'(2'b01));
      check("basic_product", p, 64'd42);
      check("basic_latency", 64'(lat), 64'(34));

      do_job(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, gnt, p, lat);
      check("max_product", p, 64'hFFFF_FFFE_0000_0001);
      do_job(0, 32'h0, 32'h1234_5678, 2'b00, gnt, p, lat);
      check("zero_product", p, 64'h0);
      check("zero_latency", 64'(lat), 64'(34));
      do_job(0, 32'h1, 32'h8000_0000, 2'b00, gnt, p, lat);
      check("msb_product", p, 64'h0000_0000_8000_0000);

      // Contention right after reset: strict alternation starting at requester 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant_q.delete();
      req_a = {32'd11, 32'd13};
      req_b = {32'd17, 32'd19};
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      n = 0;
      while (grant_q.size() < 4 && n < 1000) begin
         tick();
         n++;
      end
      req_valid = '0;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      resp_ready = '0;
      check("contention_jobs", 64'(grant_q.size()), 64'(4));
      for (int i = 0; i < 4 && i < grant_q.size(); i++)
         check($sformatf("contention_grant%0d", i), 64'(grant_q[i]), 64'(i % 2));

      // Back-pressure on requester 1 with requester 0 waiting and a wrong-index ready.
      req_a[W +: W] = 32'h0001_0000;
      req_b[W +: W] = 32'h3;
      req_a[0 +: W] = 32'd5;
      req_b[0 +: W] = 32'd8;
      req_valid = 2'b10;
      n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      req_valid  = 2'b01;
      resp_ready = 2'b01;
      n = 0;
      while (resp_valid[1] == 1'b0 && n < 100) begin
         tick();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_resp_valid", 64'(resp_valid), 64'(2'b10));
         check("bp_product", resp_product, 64'h3_0000);
         check("bp_resp_id", 64'(resp_id), 64'(1));
         check("bp_req_ready", 64'(req_ready), 64'(0));
      end
      resp_ready = 2'b10;
      tick();
      check("release_req_ready", 64'(req_ready), 64'(2'b01));
      resp_ready = 2'b01;
      tick();
      req_valid = '0;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      resp_ready = '0;

      // Reset ten cycles into a requester-0 job; the pointer must come back to 0.
      req_a[0 +: W] = 32'd9;
      req_b[0 +: W] = 32'd9;
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_busy", 64'(busy), 64'(0));
      check("midrun_resp_valid", 64'(resp_valid), 64'(0));
      do_job(0, 32'd3, 32'd5, 2'b10, gnt, p, lat);
      check("after_reset_grant", 64'(gnt), 64'(2'b01));
      check("after_reset_product", p, 64'd15);
      check("after_reset_latency", 64'(lat), 64'(34));

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 299) == 0);
         req_valid  = N'($urandom);
         req_a      = {pick_operand(), pick_operand()};
         req_b      = {pick_operand(), pick_operand()};
         resp_ready = N'($urandom);
         tick();
      end
      rst        = 1'b0;
      req_valid  = '0;
      resp_ready = 2'b11;
      repeat (LAT + 6) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one iterative shift-add integer multiplier (int_multiplier, WIDTH-cycle, start-pulse driven, no done flag) between NUM_REQ requesters, e.g. the integer MULT path and the FPU mantissa path.
- Accepts one operand pair at a time, pulses the multiplier start, and counts WIDTH iterations.
- Captures the 2*WIDTH product and returns it to the granted requester over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width; must match the attached multiplier's width.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, requester index width; 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed multiplicands; requester i is at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed multipliers; same packing as req_a.
- resp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_product  out  2*WIDTH  registered product.
- resp_id  out  ID_W  index of the owning requester.
- busy  out  1  high in any state other than IDLE.
- mul_a  out  WIDTH  to multiplier a.
- mul_b  out  WIDTH  to multiplier b.
- mul_start  out  1  to multiplier start.
- mul_product  in  2*WIDTH  from multiplier product.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0, cnt=0.
  - op_a, op_b, resp_product, resp_id = 0; mul_start=0.
  - resp_valid=0, req_ready=0, busy=0.
  - Reset mid-operation abandons the job with no response. The multiplier has no reset, so it is re-initialised by the next LOAD.
- States: IDLE -> LOAD -> RUN -> CAPT -> RESP -> IDLE.
- IDLE arbitration:
  - grant = first index g, searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ), with req_valid[g]=1.
  - req_ready[g]=1 combinationally; req_ready is 0 in every other state.
  - On the handshake edge: op_a<=req_a[g], op_b<=req_b[g], resp_id<=g, rr_ptr<=(g+1) mod NUM_REQ, state<=LOAD.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- LOAD: mul_start=1 for exactly one cycle; cnt<=WIDTH-1; ->RUN.
- RUN:
  - mul_start=0; cnt decrements each cycle.
  - When cnt==0, ->CAPT. RUN lasts exactly WIDTH cycles.
- CAPT: resp_product<=mul_product; ->RESP. This extra cycle avoids sampling on the multiplier's final accumulate edge.
- RESP:
  - resp_valid[resp_id]=1; resp_product and resp_id are held stable.
  - On resp_ready[resp_id]=1, ->IDLE.
  - resp_ready of other indices is ignored.
  - Back-pressure is unbounded.
- mul_a and mul_b are driven from op_a and op_b in all states, so they are stable through LOAD.
- Latency: resp_valid rises WIDTH+2 cycles after the request-accept edge (34 for WIDTH=32). Minimum issue interval is WIDTH+4 cycles.
- New requests are not accepted while busy; req_valid may stay high and is not dropped.
- A requester receiving its response may re-request in the first IDLE cycle. Round-robin still favours rr_ptr.
- The product is unsigned, full 2*WIDTH, with no truncation or overflow.
- Zero operands give a product of 0 with the same latency.

Test Plan:
- Setup: bench instantiates int_multiplier (WIDTH=32) wired to the mul_* ports; NUM_REQ=2.
- Reset then idle: all outputs 0 and busy=0. Req0 a=7, b=6 -> req_ready[0] in that cycle; resp_valid[0] exactly 34 cycles later; product=42, resp_id=0.
- Boundary values: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE00000001. a=0, b=0x12345678 -> 0. a=1, b=0x80000000 -> 0x0000000080000000.
- Contention: both valid at the same edge after reset -> req0 granted first. Req1 granted in the first IDLE after req0's response. Then with both still valid, req0 is granted again (strict alternation over 4 jobs).
- Back-pressure: hold resp_ready[1]=0 for 10 cycles while req0 is valid -> resp_valid[1], product and id stable; req_ready=0 throughout. Releasing resp_ready[1] -> req0 accepted the next cycle.
- Reset mid-RUN: assert rst 10 cycles into a job -> no resp_valid, busy=0, rr_ptr=0. Next job 3*5 returns 15 with normal latency.
- Wrong-index ready: resp_ready[0]=1 while the response belongs to id 1 -> the response stays pending.
